// File: rtl/fifo_pkg.sv
// Shared constants and the prefetch-buffer occupancy encoding for the
// FIFO stream reader.
package fifo_pkg;

  localparam int DW_DEF     = 8;
  localparam int CW_DEF     = 16;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry, order-preserving prefetch buffer. The head entry is always the
// oldest byte, and a simultaneous push and pop keeps the occupancy steady.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          rclk,
  input  logic          rst_,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output occ_e          occ,
  output logic          drop
);

  logic [DW-1:0] tail;

  // A push into a full buffer with no pop in the same cycle has nowhere to go.
  assign drop = push && !pop && (occ == OCC_2);

  // NOTE: the data entries are reset along with occ so that m_data reads 0 out
  // of reset. This is two registers, not a RAM, so the reset is cheap.
  // NOTE: this is sequential state, so it uses only non-blocking assignments.
  // Every branch then reads the old head/tail, which lets head <= tail and
  // tail <= din happen in the same cycle.
  always_ff @(posedge rclk) begin
    if (!rst_) begin
      occ  <= OCC_0;
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      occ <= OCC_0;
    end else begin
      unique case (occ)
        OCC_0: begin
          if (push) begin
            head <= din;
            occ  <= OCC_1;
          end
        end
        OCC_1: begin
          case ({push, pop})
            2'b10: begin
              tail <= din;
              occ  <= OCC_2;
            end
            2'b01:   occ  <= OCC_0;
            2'b11:   head <= din;
            default: ;
          endcase
        end
        OCC_2: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= din;
            else      occ  <= OCC_1;
          end
        end
        default: occ <= OCC_0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls bytes from an upstream FIFO that has one-cycle read latency and
// presents them as a valid/ready stream, counting the bytes delivered.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          rclk,
  input  logic          rst_,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_ren,
  input  logic          flush,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] byte_cnt,
  output logic          overrun
);

  occ_e       occ;
  logic       inf;
  logic       push;
  logic       pop;
  logic       drop;
  logic [2:0] pending;

  assign m_valid = (occ != OCC_0);
  assign pop     = m_valid && m_ready;
  assign push    = inf && !flush;

  // A read is issued only when the byte it returns is guaranteed a slot. That
  // slot may be one the downstream side frees in this same cycle.
  // NOTE: every signal written here gets a value on every path, so no latch is
  // inferred.
  always_comb begin
    pending  = {1'b0, occ} + {2'b00, inf} - {2'b00, pop};
    fifo_ren = rst_ && !fifo_empty && !flush && (pending < 3'(FIFO_DEPTH));
  end

  skid_buf2 #(.DW(DW)) u_buf (
    .rclk (rclk),
    .rst_ (rst_),
    .clr  (flush),
    .push (push),
    .pop  (pop),
    .din  (fifo_dout),
    .head (m_data),
    .occ  (occ),
    .drop (drop)
  );

  always_ff @(posedge rclk) begin
    if (!rst_) inf <= 1'b0;
    else       inf <= fifo_ren;
  end

  always_ff @(posedge rclk) begin
    if (!rst_)    byte_cnt <= '0;
    else if (pop) byte_cnt <= byte_cnt + CW'(1);
  end

  always_ff @(posedge rclk) begin
    if (!rst_)     overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end

  a_no_drop : assert property (@(posedge rclk) disable iff (!rst_) !drop);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader, driven by a queue-based upstream FIFO
// with one-cycle read latency. A second instance with CW=4 exercises wrap.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rst_;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          flush;
  logic          m_ready;

  logic          fifo_ren;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [CW-1:0] byte_cnt;
  logic          overrun;

  logic          fifo_ren4;
  logic [DW-1:0] m_data4;
  logic          m_valid4;
  logic [3:0]    byte_cnt4;
  logic          overrun4;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] up_q[$];

  always #5 rclk = ~rclk;

  fifo_stream_reader #(.DW(DW), .CW(CW)) u_dut (
    .rclk       (rclk),
    .rst_       (rst_),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .flush      (flush),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .byte_cnt   (byte_cnt),
    .overrun    (overrun)
  );

  fifo_stream_reader #(.DW(DW), .CW(4)) u_dut4 (
    .rclk       (rclk),
    .rst_       (rst_),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren4),
    .flush      (flush),
    .m_data     (m_data4),
    .m_valid    (m_valid4),
    .m_ready    (m_ready),
    .byte_cnt   (byte_cnt4),
    .overrun    (overrun4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the read request away from the edge, then model the
  // upstream FIFO returning data the cycle after a granted read.
  task automatic cyc();
    logic ren_s;
    @(negedge rclk);
    ren_s = fifo_ren;
    @(posedge rclk);
    #1;
    if (ren_s && up_q.size() != 0) fifo_dout = up_q.pop_front();
    fifo_empty = (up_q.size() == 0);
    #1;
  endtask

  task automatic push_up(input logic [DW-1:0] b);
    up_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  initial begin
    rst_       = 1'b0;
    flush      = 1'b0;
    m_ready    = 1'b1;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    for (int i = 0; i < 16; i++) push_up(8'h10 + 8'(i));

    // Reset held for three cycles with data available upstream.
    repeat (3) begin
      cyc();
      check("rst_ren", 32'(fifo_ren), 32'd0);
    end
    check("rst_valid",   32'(m_valid),   32'd0);
    check("rst_data",    32'(m_data),    32'd0);
    check("rst_cnt",     32'(byte_cnt),  32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    check("rst_cnt4",    32'(byte_cnt4), 32'd0);

    // Streaming 0x10..0x1F: the read goes out right after reset, and data
    // appears two cycles later.
    rst_ = 1'b1;
    #1;
    check("first_ren", 32'(fifo_ren), 32'd1);
    cyc();
    check("n1_valid", 32'(m_valid),  32'd0);
    check("n1_ren",   32'(fifo_ren), 32'd1);
    cyc();
    for (int i = 0; i < 16; i++) begin
      check("stream_valid", 32'(m_valid), 32'd1);
      check("stream_data",  32'(m_data),  32'h10 + 32'(i));
      cyc();
    end
    check("stream_cnt",   32'(byte_cnt),  32'd16);
    check("stream_idle",  32'(m_valid),   32'd0);
    check("stream_noren", 32'(fifo_ren),  32'd0);
    check("stream_cnt4",  32'(byte_cnt4), 32'd0);

    // Backpressure: the buffer fills, reads stop, and the head holds.
    m_ready = 1'b0;
    push_up(8'hA5); push_up(8'hA6); push_up(8'hA7); push_up(8'hA8);
    #1;
    repeat (3) cyc();
    check("bp_ren_full", 32'(fifo_ren), 32'd0);
    check("bp_valid",    32'(m_valid),  32'd1);
    check("bp_hold0",    32'(m_data),   32'hA5);
    cyc();
    check("bp_hold1",    32'(m_data),   32'hA5);
    check("bp_ren_hold", 32'(fifo_ren), 32'd0);
    m_ready = 1'b1;
    #1;
    check("bp_ren_pop", 32'(fifo_ren), 32'd1);
    cyc();
    check("bp_cnt17",  32'(byte_cnt),  32'd17);
    check("wrap_cnt4", 32'(byte_cnt4), 32'd1);
    check("bp_a6",     32'(m_data),    32'hA6);
    cyc();
    check("bp_a7", 32'(m_data), 32'hA7);
    cyc();
    check("bp_a8", 32'(m_data), 32'hA8);
    cyc();
    check("bp_idle",    32'(m_valid), 32'd0);
    check("bp_cnt",     32'(byte_cnt), 32'd20);
    check("bp_overrun", 32'(overrun), 32'd0);

    // Empty rises right after the last granted read; that byte still arrives.
    push_up(8'h3C);
    #1;
    check("eb_ren", 32'(fifo_ren), 32'd1);
    cyc();
    check("eb_noren1", 32'(fifo_ren), 32'd0);
    check("eb_wait",   32'(m_valid),  32'd0);
    cyc();
    check("eb_valid",  32'(m_valid),  32'd1);
    check("eb_data",   32'(m_data),   32'h3C);
    check("eb_noren2", 32'(fifo_ren), 32'd0);
    cyc();
    check("eb_idle", 32'(m_valid),  32'd0);
    check("eb_cnt",  32'(byte_cnt), 32'd21);

    // Flush with one byte buffered and one read in flight. Occupancy 2 and an
    // in-flight read cannot coexist under the issue rule, so this is the
    // fullest reachable state.
    m_ready = 1'b0;
    push_up(8'hB0); push_up(8'hB1); push_up(8'hB2);
    #1;
    repeat (2) cyc();
    check("fl_pre_valid", 32'(m_valid), 32'd1);
    check("fl_pre_data",  32'(m_data),  32'hB0);
    flush = 1'b1;
    #1;
    check("fl_ren", 32'(fifo_ren), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    check("fl_valid",   32'(m_valid),  32'd0);
    check("fl_cnt",     32'(byte_cnt), 32'd21);
    check("fl_ren_resume", 32'(fifo_ren), 32'd1);
    m_ready = 1'b1;
    cyc();
    check("fl_wait", 32'(m_valid), 32'd0);
    cyc();
    check("fl_next_valid", 32'(m_valid), 32'd1);
    check("fl_next_data",  32'(m_data),  32'hB2);
    cyc();
    check("fl_cnt_after", 32'(byte_cnt), 32'd22);
    check("fl_overrun",   32'(overrun),  32'd0);

    // Reset while the buffer is full: contents are discarded, and reading
    // resumes the cycle after rst_ rises.
    m_ready = 1'b0;
    push_up(8'hD0); push_up(8'hD1);
    #1;
    repeat (3) cyc();
    check("mr_pre_data", 32'(m_data), 32'hD0);
    rst_ = 1'b0;
    cyc();
    check("mr_valid", 32'(m_valid),  32'd0);
    check("mr_data",  32'(m_data),   32'd0);
    check("mr_cnt",   32'(byte_cnt), 32'd0);
    check("mr_ren",   32'(fifo_ren), 32'd0);
    push_up(8'h5A);
    rst_    = 1'b1;
    m_ready = 1'b1;
    #1;
    check("mr_first_ren", 32'(fifo_ren), 32'd1);
    repeat (2) cyc();
    check("mr_valid2", 32'(m_valid), 32'd1);
    check("mr_data2",  32'(m_data),  32'h5A);
    cyc();
    check("mr_cnt2", 32'(byte_cnt), 32'd1);
    check("mr_idle", 32'(m_valid),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
